// File: rtl/pool_out_writer_pkg.sv
// -----------------------------------------------------------------------------
// pool_out_writer_pkg
// Shared definitions for the pool output writer:
//   - window-size encodings as seen on the pool_window_size port
//   - FSM state enum for the writer
//   - internal log2 window code and the per-window lookup helpers
//     (lanes carried per beat, index of the last slot in a word)
// -----------------------------------------------------------------------------
package pool_out_writer_pkg;

  // Window encodings on the pool_window_size port.
  localparam logic [31:0] POOL_W1 = 32'd1;
  localparam logic [31:0] POOL_W2 = 32'd2;
  localparam logic [31:0] POOL_W4 = 32'd4;

  // Slot counter width: a word holds at most 4 beats (w=4).
  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Internal window code: the value is log2(w).
  typedef enum logic [1:0] {
    WSEL_1 = 2'd0,
    WSEL_2 = 2'd1,
    WSEL_4 = 2'd2
  } wsel_e;

  // Illegal window sizes collapse to w=1.
  function automatic wsel_e decode_window(input logic [31:0] w);
    case (w)
      POOL_W2: return WSEL_2;
      POOL_W4: return WSEL_4;
      default: return WSEL_1;
    endcase
  endfunction

  function automatic logic window_legal(input logic [31:0] w);
    return (w == POOL_W1) || (w == POOL_W2) || (w == POOL_W4);
  endfunction

  // Valid lanes carried by one pooled beat.
  function automatic int lanes_per_beat(input int mat_mul_size, input wsel_e w);
    case (w)
      WSEL_2:  return mat_mul_size / 2;
      WSEL_4:  return mat_mul_size / 4;
      default: return mat_mul_size;
    endcase
  endfunction

  // Slot index of the beat that completes a word.
  function automatic logic [SLOT_W-1:0] slot_last(input wsel_e w);
    case (w)
      WSEL_2:  return 2'd1;
      WSEL_4:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pool_lane_packer.sv
// -----------------------------------------------------------------------------
// pool_lane_packer
// Holds the partially assembled output word and the slot counter. Each
// accepted beat drops its valid low lanes into the next free slot.
//   clk, reset    clock, async active-high reset
//   w_i           window code (log2 w)
//   beat_i        pooled beat, valid lanes in the LSBs
//   accept_i      consume beat_i this cycle
//   clear_i       discard the partial word (wins over accept_i)
//   word_o        packed word including the beat being accepted, if any
//   word_full_o   the beat being accepted completes the word
//   pending_o     a partial word is held (slot != 0)
// A completing beat self-clears the register so a back-to-back beat lands in
// slot 0 of a fresh word on the very next edge.
// -----------------------------------------------------------------------------
module pool_lane_packer
  import pool_out_writer_pkg::*;
#(
  parameter int MAT_MUL_SIZE = 4,
  parameter int DWIDTH       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  wsel_e                          w_i,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] beat_i,
  input  logic                           accept_i,
  input  logic                           clear_i,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] word_o,
  output logic                           word_full_o,
  output logic                           pending_o
);

  localparam int WORD_W = MAT_MUL_SIZE * DWIDTH;

  logic [WORD_W-1:0] pack_q;
  logic [WORD_W-1:0] pack_d;
  logic [SLOT_W-1:0] slot_q;
  int                lanes;
  int                lane_base;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lanes     = lanes_per_beat(MAT_MUL_SIZE, w_i);
    lane_base = int'(slot_q) * lanes;
    pack_d    = pack_q;
    for (int l = 0; l < MAT_MUL_SIZE; l++) begin
      if (l >= lane_base && l < lane_base + lanes) begin
        pack_d[l*DWIDTH +: DWIDTH] = beat_i[(l - lane_base)*DWIDTH +: DWIDTH];
      end
    end
  end

  assign word_full_o = accept_i && (slot_q == slot_last(w_i));
  assign word_o      = accept_i ? pack_d : pack_q;
  assign pending_o   = (slot_q != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_q <= '0;
      slot_q <= '0;
    end else if (clear_i) begin
      pack_q <= '0;
      slot_q <= '0;
    end else if (accept_i) begin
      if (word_full_o) begin
        pack_q <= '0;
        slot_q <= '0;
      end else begin
        pack_q <= pack_d;
        slot_q <= slot_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_out_writer.sv
// -----------------------------------------------------------------------------
// pool_out_writer
// Consumer end of the pooling stage. Absorbs num_beats pooled beats, repacks
// w beats (each MAT_MUL_SIZE/w lanes) into full words and writes them to the
// output BRAM at consecutive addresses from base_addr, then reports done.
//   clk, reset          clock, async active-high reset
//   enable_wr           level start/hold; low returns to IDLE
//   pool_window_size    window w (1,2,4; others act as 1), latched from IDLE
//   num_beats           beats to absorb, latched from IDLE
//   base_addr           first write address, latched from IDLE
//   in_data_available   inp_data valid this cycle
//   inp_data            pooled beat, lane 0 in the LSBs
//   bram_addr/wdata/we  registered BRAM write port; addr holds when we=0
//   busy                COLLECT or FLUSH
//   done_wr             DONE
//   err_wr              (only with POOL_WR_ERR_EN) sticky: illegal window
//                       latched, or beat seen in FLUSH/DONE; cleared on
//                       entry to IDLE
// Optional feature macro: POOL_WR_ERR_EN.
// -----------------------------------------------------------------------------
module pool_out_writer
  import pool_out_writer_pkg::*;
#(
  parameter int MAT_MUL_SIZE  = 4,
  parameter int DWIDTH        = 8,
  parameter int AWIDTH        = 10,
  parameter int MAX_BITS_POOL = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_wr,
  input  logic [MAX_BITS_POOL-1:0]       pool_window_size,
  input  logic [AWIDTH-1:0]              num_beats,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic                           bram_we,
  output logic                           busy,
  output logic                           done_wr
`ifdef POOL_WR_ERR_EN
  ,
  output logic                           err_wr
`endif
);

  localparam int WORD_W = MAT_MUL_SIZE * DWIDTH;

  state_e            state_q;
  state_e            state_d;
  wsel_e             wsel_q;
  logic [AWIDTH-1:0] num_q;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH-1:0] cnt_q;

  logic              accept;
  logic              flush_write;
  logic              pack_clear;
  logic              last_beat;
  logic [WORD_W-1:0] word;
  logic              word_full;
  logic              pending;

  // Beats beyond num_beats are never accepted.
  assign accept      = (state_q == ST_COLLECT) && enable_wr && in_data_available
                       && (cnt_q != num_q);
  assign flush_write = (state_q == ST_FLUSH) && enable_wr && pending;
  // Dropping enable_wr discards any partial word; IDLE/DONE keep it empty.
  assign pack_clear  = !enable_wr || (state_q == ST_IDLE) || (state_q == ST_DONE)
                       || flush_write;
  assign last_beat   = (cnt_q == num_q - 1'b1);

  pool_lane_packer #(
    .MAT_MUL_SIZE (MAT_MUL_SIZE),
    .DWIDTH       (DWIDTH)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .w_i         (wsel_q),
    .beat_i      (inp_data),
    .accept_i    (accept),
    .clear_i     (pack_clear),
    .word_o      (word),
    .word_full_o (word_full),
    .pending_o   (pending)
  );

  // A full last word keeps the FSM in COLLECT for its write cycle, so done_wr
  // always rises the cycle after the final bram_we, as it does after FLUSH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_wr) state_d = (num_beats == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!enable_wr)                             state_d = ST_IDLE;
        else if (cnt_q == num_q)                    state_d = ST_DONE;
        else if (accept && last_beat && !word_full) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!enable_wr)    state_d = ST_IDLE;
        else if (!pending) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!enable_wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wsel_q     <= WSEL_1;
      num_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_we    <= 1'b0;
      busy       <= 1'b0;
      done_wr    <= 1'b0;
    end else begin
      state_q <= state_d;
      bram_we <= 1'b0;
      busy    <= (state_d == ST_COLLECT) || (state_d == ST_FLUSH);
      done_wr <= (state_d == ST_DONE);

      if (state_q == ST_IDLE && enable_wr) begin
        wsel_q <= decode_window(32'(pool_window_size));
        num_q  <= num_beats;
        addr_q <= base_addr;
        cnt_q  <= '0;
      end

      if (accept) cnt_q <= cnt_q + 1'b1;

      if (word_full || flush_write) begin
        bram_we    <= 1'b1;
        bram_wdata <= word;
        bram_addr  <= addr_q;
        addr_q     <= addr_q + 1'b1;
      end
    end
  end

`ifdef POOL_WR_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_wr <= 1'b0;
    end else if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      err_wr <= 1'b0;
    end else if ((state_q == ST_IDLE && enable_wr &&
                  !window_legal(32'(pool_window_size))) ||
                 ((state_q == ST_DONE || state_q == ST_FLUSH) && in_data_available)) begin
      err_wr <= 1'b1;
    end
  end
`endif

endmodule
